// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the CPU load/store interface
//
// Purpose: memory-side end of the LW/SW path. Accepts one request at a time,
// holds it for LATENCY edges, commits the access to a DEPTH x 16-bit array,
// then presents a response until the initiator takes it.
//
// Ports:
//   clock       in   1   system clock, rising-edge
//   reset       in   1   synchronous active-high reset (memory is not cleared)
//   req_valid   in   1   request present
//   req_ready   out  1   responder idle and able to accept
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   16  byte address, halfword aligned
//   req_wdata   in   16  store data
//   resp_valid  out  1   response present
//   resp_ready  in   1   initiator takes the response
//   resp_rdata  out  16  load data; 0 for stores and errors
//   resp_err    out  1   misaligned or out-of-range address

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          cmt_err;
  logic [IW-1:0] idx;

  assign idx     = lat_addr[IW:1];
  assign cmt_err = lat_addr[0] | (32'(lat_addr[15:1]) >= 32'(DEPTH));

  // cnt holds the number of WAIT edges still to pass before the commit edge;
  // loading LATENCY-1 on accept makes the commit land LATENCY edges later.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 16'd0;
      lat_wdata  <= 16'd0;
      resp_rdata <= 16'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err   <= cmt_err;
        resp_rdata <= (!cmt_err && !lat_we) ? mem[idx] : 16'd0;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= 16'd0;
      end
    end
  end

  // Storage has no reset; the reset term only blocks a commit on a reset edge.
  always_ff @(posedge clock) begin
    if (!reset && commit && lat_we && !cmt_err) begin
      mem[idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2, 1 and 4

module tb_dmem_responder;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] reset;
  logic [NI-1:0] req_valid, req_ready, req_we;
  logic [NI-1:0] resp_valid, resp_ready, resp_err;
  logic [15:0]   req_addr   [NI];
  logic [15:0]   req_wdata  [NI];
  logic [15:0]   resp_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (256),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clock      (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   acc_cyc [NI];
  logic [NI-1:0] prev_rv = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // Monitor: latency from accept edge to resp_valid rise, and response contents
  // checked against the scoreboard at each handshake.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!reset[k]) begin
        if (req_valid[k] && req_ready[k]) acc_cyc[k] = cyc + 1;
        if (resp_valid[k] && !prev_rv[k]) chk("latency", k, cyc - acc_cyc[k], lat_of(k));
        if (resp_valid[k] && resp_ready[k]) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", k, 1, 0);
          end else begin
            mon_e = q.pop_front();
            chk("resp_inst",  k, k,             mon_e.inst);
            chk("resp_rdata", k, resp_rdata[k], mon_e.rdata);
            chk("resp_err",   k, resp_err[k],   mon_e.err);
          end
        end
      end
      prev_rv[k] = resp_valid[k];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm, input int k);
    chk({nm, "_req_ready"},  k, req_ready[k],  1);
    chk({nm, "_resp_valid"}, k, resp_valid[k], 0);
    chk({nm, "_resp_rdata"}, k, resp_rdata[k], 0);
    chk({nm, "_resp_err"},   k, resp_err[k],   0);
  endtask

  task automatic issue(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee, input bit expect_resp);
    int n;
    req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 100) begin step(); n++; end
    if (n >= 100) chk("accept_timeout", k, 0, 1);
    if (expect_resp) q.push_back('{k, er, ee});
    step();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!resp_valid[k] && n < 100) begin step(); n++; end
    if (n >= 100) chk("resp_timeout", k, 0, 1);
  endtask

  task automatic finish_resp(input int k);
    resp_ready[k] = 1'b1;
    wait_valid(k);
    step();
    resp_ready[k] = 1'b0;
  endtask

  task automatic xact(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] er, input logic ee);
    issue(k, we, a, d, er, ee, 1'b1);
    finish_resp(k);
  endtask

  task automatic stream(input int k, input int nx);
    int cnt, prev, guard;
    resp_ready[k] = 1'b1;
    req_we[k] = 1'b0; req_addr[k] = 16'h000E; req_wdata[k] = 16'h0;
    req_valid[k] = 1'b1;
    cnt = 0; prev = 0; guard = 0;
    while (cnt < nx && guard < 200) begin
      if (req_ready[k]) begin
        q.push_back('{k, 16'h0016, 1'b0});
        if (cnt > 0) chk("period", k, cyc + 1 - prev, lat_of(k) + 2);
        prev = cyc + 1;
        cnt++;
      end
      step();
      guard++;
    end
    req_valid[k] = 1'b0;
    if (guard >= 200) chk("stream_timeout", k, 0, 1);
    guard = 0;
    while (q.size() != 0 && guard < 200) begin step(); guard++; end
    if (guard >= 200) chk("drain_timeout", k, 0, 1);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = '1; req_valid = '0; req_we = '0; resp_ready = '0;
    for (int k = 0; k < NI; k++) begin req_addr[k] = 16'h0; req_wdata[k] = 16'h0; acc_cyc[k] = 0; end
    step(); step();
    for (int k = 0; k < NI; k++) chk_idle("reset", k);
    reset = '0;
    step();

    // 1: store then load back at LATENCY=2
    xact(0, 1'b1, 16'h000E, 16'h0016, 16'h0000, 1'b0);
    xact(0, 1'b0, 16'h000E, 16'h0000, 16'h0016, 1'b0);

    // 2: response held under backpressure; concurrent request waits
    issue(0, 1'b0, 16'h000E, 16'h0000, 16'h0016, 1'b0, 1'b1);
    wait_valid(0);
    req_we[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'h0099; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 0, resp_valid[0], 1);
      chk("hold_rdata", 0, resp_rdata[0], 16'h0016);
      chk("hold_err",   0, resp_err[0],   0);
      chk("hold_ready", 0, req_ready[0],  0);
    end
    q.push_back('{0, 16'h0000, 1'b0});
    resp_ready[0] = 1'b1;
    step();
    resp_ready[0] = 1'b0;
    chk("post_hs_valid", 0, resp_valid[0], 0);
    chk("post_hs_ready", 0, req_ready[0],  1);
    step();
    req_valid[0] = 1'b0;
    chk("accepted_ready", 0, req_ready[0], 0);
    finish_resp(0);
    xact(0, 1'b0, 16'h0010, 16'h0000, 16'h0099, 1'b0);

    // 3: misaligned store does not touch memory
    xact(0, 1'b1, 16'h0002, 16'h0007, 16'h0000, 1'b0);
    xact(0, 1'b1, 16'h0003, 16'hBEEF, 16'h0000, 1'b1);
    xact(0, 1'b0, 16'h0002, 16'h0000, 16'h0007, 1'b0);

    // 4: range boundary
    xact(0, 1'b1, 16'h01FE, 16'hA5A5, 16'h0000, 1'b0);
    xact(0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1);
    xact(0, 1'b0, 16'h01FE, 16'h0000, 16'hA5A5, 1'b0);

    // 5: reset in WAIT abandons the store
    xact(0, 1'b1, 16'h0004, 16'h5555, 16'h0000, 1'b0);
    issue(0, 1'b1, 16'h0004, 16'h1234, 16'h0000, 1'b0, 1'b0);
    reset[0] = 1'b1;
    step();
    chk_idle("rst_wait", 0);
    reset[0] = 1'b0;
    step(); step(); step();
    chk("rst_wait_quiet", 0, resp_valid[0], 0);
    xact(0, 1'b0, 16'h0004, 16'h0000, 16'h5555, 1'b0);

    // reset in RESP drops the response but keeps the committed store
    issue(0, 1'b1, 16'h0006, 16'h4321, 16'h0000, 1'b0, 1'b0);
    wait_valid(0);
    reset[0] = 1'b1;
    step();
    chk_idle("rst_resp", 0);
    reset[0] = 1'b0;
    step();
    xact(0, 1'b0, 16'h0006, 16'h0000, 16'h4321, 1'b0);

    // 6: LATENCY=1 and LATENCY=4, plus back-to-back throughput
    for (int k = 1; k < NI; k++) begin
      xact(k, 1'b1, 16'h000E, 16'h0016, 16'h0000, 1'b0);
      xact(k, 1'b0, 16'h000E, 16'h0000, 16'h0016, 1'b0);
      stream(k, 4);
    end
    stream(0, 4);

    step(); step();
    chk("queue_empty", 0, q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
